mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles to wait for dmem_ack before aborting an access.
REQ-002 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have ports valid_in in 1, op in 6, load in 1, store in 1, wr_en_in in 1: executed-instruction qualifier, opcode and ALU control flags.
REQ-005 SHALL have ports mem_addr in 32, store_data in 32, result_in in 32, rd_in in 5: ALU address, rs2 value, ALU result, destination register.
REQ-006 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32 (bits[1:0]=0), dmem_be out 4, dmem_wdata out 32, dmem_rdata in 32, dmem_ack in 1.
REQ-007 SHALL have ports stall out 1, wb_valid out 1, wb_en out 1, wb_rd out 5, wb_data out 32, misaligned_err out 1, timeout_err out 1.

Function
REQ-008 Opcode decode SHALL be: 010011 LB, 010100 LH, 010101 LW, 010110 LBU, 010111 LHU, 011000 SB, 011001 SH, 011010 SW; any other op with valid_in is a pass-through.
REQ-009 A load SHALL require load=1 and a load opcode; a store SHALL require store=1 and a store opcode; a flag/opcode mismatch SHALL count as pass-through with wb_en=0.
REQ-010 FSM states SHALL be IDLE and BUSY; transitions: IDLE->BUSY on an accepted aligned memory op; BUSY->IDLE on dmem_ack or timeout.
REQ-011 valid_in SHALL be sampled only in IDLE; valid_in in BUSY SHALL be ignored.
REQ-012 stall SHALL be combinational: high when (IDLE and valid_in and aligned memory op) or BUSY and not (dmem_ack or timeout expiring this cycle).
REQ-013 Pass-through: one cycle after acceptance, wb_valid=1, wb_en=wr_en_in, wb_rd=rd_in, wb_data=result_in; latency exactly 1.
REQ-014 Memory op: dmem_req SHALL rise the cycle after acceptance and hold, with dmem_we/addr/be/wdata stable, until the cycle dmem_ack is sampled high.
REQ-015 dmem_addr SHALL be {mem_addr[31:2],2'b00} registered at acceptance.
REQ-016 Store lanes: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=4'b0011<<addr[1:0], wdata=half replicated x2; SW be=4'b1111.
REQ-017 Loads SHALL drive dmem_we=0 and dmem_be per REQ-016 size rules.
REQ-018 Load data SHALL be lane-selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-019 On dmem_ack: load -> next cycle wb_valid=1, wb_en=1, wb_data=extended data, wb_rd; store -> next cycle wb_valid=1, wb_en=0.
REQ-020 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus request, no stall, next cycle misaligned_err=1 for one cycle, wb_valid=1, wb_en=0.
REQ-021 BUSY SHALL count cycles with dmem_req high; on reaching TIMEOUT_CYCLES without ack, deassert dmem_req, return IDLE, pulse timeout_err one cycle with wb_valid=1, wb_en=0.
REQ-022 dmem_ack in IDLE SHALL be ignored; ack and timeout in the same cycle SHALL resolve as ack.
REQ-023 wb_valid, misaligned_err, timeout_err SHALL be single-cycle pulses per instruction; wb_en SHALL never be high while wb_valid is low.
REQ-024 rd_in=0 SHALL force wb_en=0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, and dmem_req, dmem_we, dmem_be, wb_valid, wb_en, misaligned_err, timeout_err, stall-state to 0; dmem_addr, dmem_wdata, wb_rd, wb_data to 0.
REQ-026 Reset during BUSY SHALL abandon the access with no writeback and no error pulse; first accept possible on the first edge after release.

Verification
REQ-027 Pass-through: op=000000, result_in=0x0000_0007, rd_in=5, wr_en_in=1 -> next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=7, stall never high.
REQ-028 LB addr=0x1003, dmem_rdata=0x8000_0000, ack after 3 cycles -> dmem_addr=0x1000, be=0001<<3=1000, stall 4 cycles, wb_data=0xFFFF_FF80.
REQ-029 SH addr=0x2002, store_data=0x0000_ABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD, wb_en=0 after ack.
REQ-030 LW addr=0x3001 -> no dmem_req, misaligned_err pulse next cycle, wb_en=0.
REQ-031 LHU with dmem_ack never asserted, TIMEOUT_CYCLES=4 -> dmem_req high 4 cycles, timeout_err pulse, FSM IDLE, next valid_in accepted.
REQ-032 rst_n low 2 cycles into a pending LW -> dmem_req and stall drop at once, no wb_valid, no error pulse.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: decodes loads/stores, runs one data-bus access at a time, and
// produces a single-cycle writeback pulse for pass-through, load, store and error results.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  op,
  input  logic        load,
  input  logic        store,
  input  logic        wr_en_in,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] result_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned_err,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ld_q;
  size_t         size_q;
  logic          sign_q;
  logic [1:0]    lane_q;
  logic [4:0]    rd_q;

  logic        is_ld_op, is_st_op, sign, mismatch, mem_op, misaligned, expiring;
  size_t       size;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [15:0] lane_data;
  logic [31:0] ld_data;

  always_comb begin
    is_ld_op = 1'b0;
    is_st_op = 1'b0;
    size     = SZ_W;
    sign     = 1'b0;
    case (op)
      6'b010011: begin is_ld_op = 1'b1; size = SZ_B; sign = 1'b1; end
      6'b010100: begin is_ld_op = 1'b1; size = SZ_H; sign = 1'b1; end
      6'b010101: begin is_ld_op = 1'b1; size = SZ_W; end
      6'b010110: begin is_ld_op = 1'b1; size = SZ_B; end
      6'b010111: begin is_ld_op = 1'b1; size = SZ_H; end
      6'b011000: begin is_st_op = 1'b1; size = SZ_B; end
      6'b011001: begin is_st_op = 1'b1; size = SZ_H; end
      6'b011010: begin is_st_op = 1'b1; size = SZ_W; end
      default: ;
    endcase
    // Either control flag disagreeing with the opcode demotes the instruction to a dead pass-through
    mismatch   = (load != is_ld_op) || (store != is_st_op);
    mem_op     = (is_ld_op || is_st_op) && !mismatch;
    misaligned = ((size == SZ_H) && mem_addr[0]) || ((size == SZ_W) && (mem_addr[1:0] != 2'b00));
    case (size)
      SZ_B:    begin be_calc = 4'b0001 << mem_addr[1:0]; wdata_calc = {4{store_data[7:0]}};  end
      SZ_H:    begin be_calc = 4'b0011 << mem_addr[1:0]; wdata_calc = {2{store_data[15:0]}}; end
      default: begin be_calc = 4'b1111;                  wdata_calc = store_data;           end
    endcase
  end

  always_comb begin
    lane_data = 16'(dmem_rdata >> {lane_q, 3'b000});
    case (size_q)
      SZ_B:    ld_data = sign_q ? {{24{lane_data[7]}}, lane_data[7:0]}   : {24'h0, lane_data[7:0]};
      SZ_H:    ld_data = sign_q ? {{16{lane_data[15]}}, lane_data[15:0]} : {16'h0, lane_data[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign expiring = (state == BUSY) && !dmem_ack && (cnt == CNT_LAST);
  // Held low during reset so an upstream instruction waiting on us is released immediately
  assign stall = rst_n && (((state == IDLE) && valid_in && mem_op && !misaligned) ||
                           ((state == BUSY) && !dmem_ack && !expiring));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ld_q           <= 1'b0;
      size_q         <= SZ_B;
      sign_q         <= 1'b0;
      lane_q         <= '0;
      rd_q           <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_en          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      wb_en          <= 1'b0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            wb_rd <= rd_in;
            if (mem_op && !misaligned) begin
              state      <= BUSY;
              cnt        <= '0;
              ld_q       <= is_ld_op;
              size_q     <= size;
              sign_q     <= sign;
              lane_q     <= mem_addr[1:0];
              rd_q       <= rd_in;
              dmem_req   <= 1'b1;
              dmem_we    <= is_st_op;
              dmem_addr  <= {mem_addr[31:2], 2'b00};
              dmem_be    <= be_calc;
              dmem_wdata <= is_st_op ? wdata_calc : '0;
            end else if (mem_op) begin
              wb_valid       <= 1'b1;
              misaligned_err <= 1'b1;
              wb_data        <= '0;
            end else begin
              wb_valid <= 1'b1;
              wb_en    <= wr_en_in && !mismatch && (rd_in != 5'd0);
              wb_data  <= result_in;
            end
          end
        end
        BUSY: begin
          if (dmem_ack || expiring) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_be     <= '0;
            wb_valid    <= 1'b1;
            wb_rd       <= rd_q;
            wb_en       <= dmem_ack && ld_q && (rd_q != 5'd0);
            wb_data     <= (dmem_ack && ld_q) ? ld_data : '0;
            timeout_err <= !dmem_ack;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
